signed_adder_bcd_display: RTL and testbench

- Registered, parametrised signed add/subtract unit with a sequential binary-to-BCD converter (shift-add-3) driving NDIG active-low seven-segment digits, a sign digit and an overflow flag.
- Successor to the 4-bit combinational lab adder: arbitrary width, add/sub mode, valid/ready handshake, multi-digit decimal display.
- Sits between board switches/host logic and the HEX displays.

---
 rtl/signed_adder_pkg.sv | 43 ++++
 rtl/signed_adder_bcd_display_bin2bcd_serial.sv | 60 ++++++
 rtl/signed_adder_bcd_display.sv | 128 ++++++++++++
 tb/tb_signed_adder_bcd_display.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/signed_adder_pkg.sv
// Shared types and constants for the signed adder with BCD seven-segment display:
// active-low gfedcba digit patterns, controller states and the nibble decoder.
package signed_adder_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/signed_adder_bcd_display_bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3), one bit per cycle for WIDTH cycles.
// bcd holds the last finished conversion and only changes on the final iteration.
module bin2bcd_serial #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_bin;
  logic [4*NDIG-1:0] r_work;
  logic [4*NDIG-1:0] r_bcd;
  logic [4*NDIG-1:0] w_adj;
  logic [4*NDIG-1:0] w_next;

  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < NDIG; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
    w_next = {w_adj[4*NDIG-2:0], r_bin[WIDTH-1]};
  end

  assign busy = (r_cnt != '0);
  assign done = (r_cnt == CW'(1));
  assign bcd  = r_bcd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_bcd <= '0;
    end else if (start) begin
      r_cnt <= CW'(WIDTH);
    end else if (busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (done) r_bcd <= w_next;
    end
  end

  // working shift registers carry no reset; start always reinitialises them
  always_ff @(posedge clk) begin
    if (start) begin
      r_bin  <= bin;
      r_work <= '0;
    end else if (busy) begin
      r_bin  <= {r_bin[WIDTH-2:0], 1'b0};
      r_work <= w_next;
    end
  end

endmodule

// File: rtl/signed_adder_bcd_display.sv
// Registered signed add/subtract with decimal seven-segment readout of the wrapped result.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero one.
module signed_adder_bcd_display
  import signed_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                sub,
  output logic [WIDTH-1:0]    result,
  output logic                overflow,
  output logic                out_valid,
  output logic [7*NDIG-1:0]   seg,
  output logic [6:0]          seg_sign
);

  if (pow10(NDIG) <= (longint'(1) << (WIDTH - 1))) begin : g_ndig_check
    $error("NDIG too small: 10**NDIG must exceed 2**(WIDTH-1)");
  end

  state_t               r_state;
  logic [WIDTH-1:0]     r_result;
  logic                 r_ovf;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_sum_hold;
  logic                 r_ovf_hold;

  logic signed [WIDTH:0] w_a_ext;
  logic signed [WIDTH:0] w_b_ext;
  logic signed [WIDTH:0] w_b_op;
  logic signed [WIDTH:0] w_sum;
  logic                  w_ovf;
  logic [WIDTH-1:0]      w_res;
  logic [WIDTH-1:0]      w_mag;
  logic                  w_start;
  logic                  w_busy;
  logic                  w_done;
  logic [4*NDIG-1:0]     w_bcd;
  logic [7*NDIG-1:0]     w_seg;

  // One guard bit makes -b exact for the most negative b and exposes overflow.
  assign w_a_ext = {a[WIDTH-1], a};
  assign w_b_ext = {b[WIDTH-1], b};
  assign w_b_op  = sub ? -w_b_ext : w_b_ext;
  assign w_sum   = w_a_ext + w_b_op;
  assign w_ovf   = w_sum[WIDTH] ^ w_sum[WIDTH-1];
  assign w_res   = w_sum[WIDTH-1:0];
  assign w_mag   = w_res[WIDTH-1] ? -w_res : w_res;

  assign in_ready = (r_state == IDLE) && !w_busy && !reset;
  assign w_start  = in_valid && in_ready;

  bin2bcd_serial #(.WIDTH(WIDTH), .NDIG(NDIG)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .bin   (w_mag),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (w_start) r_state <= CONV;
        end
        CONV: begin
          if (w_done) begin
            r_result    <= r_sum_hold;
            r_ovf       <= r_ovf_hold;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_sum_hold <= w_res;
      r_ovf_hold <= w_ovf;
    end
  end

  always_comb begin
    w_seg = '0;
    for (int i = 0; i < NDIG; i++) w_seg[7*i +: 7] = bcd_to_seg7(w_bcd[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank_leading
      logic w_lead;
      w_lead = 1'b1;
      for (int i = NDIG - 1; i > 0; i--) begin
        if (w_bcd[4*i +: 4] != 4'd0) w_lead = 1'b0;
        if (w_lead) w_seg[7*i +: 7] = SEG_BLANK;
      end
    end
`else
    w_seg = w_seg;
`endif
  end

  assign result    = r_result;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;
  assign seg       = w_seg;
  assign seg_sign  = r_result[WIDTH-1] ? SEG_MINUS : SEG_BLANK;

endmodule

// File: tb/tb_signed_adder_bcd_display.sv
// Scoreboard bench for signed_adder_bcd_display (WIDTH=8, NDIG=3) with an integer reference model.
module tb_signed_adder_bcd_display;

  localparam int W    = 8;
  localparam int N    = 3;
  localparam int HALF = 1 << (W - 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           sub = 1'b0;
  logic [W-1:0]   result;
  logic           overflow;
  logic           out_valid;
  logic [7*N-1:0] seg;
  logic [6:0]     seg_sign;

  signed_adder_bcd_display #(.WIDTH(W), .NDIG(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .result    (result),
    .overflow  (overflow),
    .out_valid (out_valid),
    .seg       (seg),
    .seg_sign  (seg_sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   res;
    logic           ovf;
    logic [7*N-1:0] seg;
    logic [6:0]     sgn;
    int             cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   n_push = 0;
  int   n_ov   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input int av, input int bv, input bit s, input int c);
    exp_t e;
    int sum, wr, mag, p;
    sum   = av + (s ? -bv : bv);
    e.ovf = (sum >= HALF) || (sum < -HALF);
    wr    = sum;
    if (wr >= HALF) wr -= 2 * HALF;
    else if (wr < -HALF) wr += 2 * HALF;
    e.res = wr[W-1:0];
    mag   = (wr < 0) ? -wr : wr;
    p     = 1;
    e.seg = '0;
    for (int i = 0; i < N; i++) begin
      e.seg[7*i +: 7] = seg_of((mag / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && mag < p) e.seg[7*i +: 7] = 7'b1111111;
`endif
      p = p * 10;
    end
    e.sgn = (wr < 0) ? 7'b0111111 : 7'b1111111;
    e.cyc = c;
    return e;
  endfunction

  // Monitor: out_valid timing, popped results, and output stability between updates.
  exp_t           m_e;
  logic [W-1:0]   l_res;
  logic           l_ovf;
  logic [7*N-1:0] l_seg;
  logic [6:0]     l_sgn;
  logic           want_ov;

  always @(negedge clk) begin
    if (reset) begin
      m_e   = model(0, 0, 1'b0, 0);
      l_res = m_e.res;
      l_ovf = m_e.ovf;
      l_seg = m_e.seg;
      l_sgn = m_e.sgn;
    end else begin
      want_ov = (q.size() != 0) && (q[0].cyc + W + 1 == cyc);
      chk("out_valid", 32'(out_valid), 32'(want_ov));
      if (out_valid) begin
        n_ov++;
        if (q.size() != 0) begin
          m_e = q.pop_front();
          chk("result",   32'(result),   32'(m_e.res));
          chk("overflow", 32'(overflow), 32'(m_e.ovf));
          chk("seg",      32'(seg),      32'(m_e.seg));
          chk("seg_sign", 32'(seg_sign), 32'(m_e.sgn));
          l_res = m_e.res;
          l_ovf = m_e.ovf;
          l_seg = m_e.seg;
          l_sgn = m_e.sgn;
        end
      end else begin
        chk("hold_seg", 32'(seg), 32'(l_seg));
        chk("hold_res_ovf_sign", 32'({result, overflow, seg_sign}), 32'({l_res, l_ovf, l_sgn}));
      end
    end
  end

  task automatic do_op(input int av, input int bv, input bit s, input bit expect_out, input bit hold);
    int n;
    @(posedge clk); #1;
    a        = av[W-1:0];
    b        = bv[W-1:0];
    sub      = s;
    in_valid = 1'b1;
    n        = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        chk("in_ready_wait", 32'(in_ready), 32'(1));
        in_valid = 1'b0;
        return;
      end
    end
    if (expect_out) begin
      q.push_back(model(av, bv, s, cyc));
      n_push++;
    end
    @(posedge clk); #1;
    if (hold) begin
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'b1;
      repeat (5) @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  exp_t rst_e;

  initial begin
    int n;
    rst_e = model(0, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result",    32'(result),    32'(rst_e.res));
    chk("rst_overflow",  32'(overflow),  32'(rst_e.ovf));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_seg",       32'(seg),       32'(rst_e.seg));
    chk("rst_seg_sign",  32'(seg_sign),  32'(rst_e.sgn));
    chk("rst_in_ready",  32'(in_ready),  32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'(1));

    do_op(100, 27, 1'b0, 1'b1, 1'b0);
    do_op(100, 28, 1'b0, 1'b1, 1'b0);
    do_op(-5, 3, 1'b1, 1'b1, 1'b0);
    do_op(0, -128, 1'b1, 1'b1, 1'b0);
    do_op(-1, -128, 1'b1, 1'b1, 1'b0);
    do_op(-128, -128, 1'b0, 1'b1, 1'b0);
    do_op(127, 127, 1'b0, 1'b1, 1'b0);
    do_op(-128, 1, 1'b1, 1'b1, 1'b0);
    do_op(0, 0, 1'b0, 1'b1, 1'b0);
    do_op(55, -20, 1'b0, 1'b1, 1'b1);

    // Abort a conversion with reset in its fourth CONV cycle.
    do_op(-100, -100, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_result",   32'(result),   32'(rst_e.res));
    chk("abort_overflow", 32'(overflow), 32'(rst_e.ovf));
    chk("abort_seg",      32'(seg),      32'(rst_e.seg));
    chk("abort_seg_sign", 32'(seg_sign), 32'(rst_e.sgn));
    chk("abort_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", 32'(in_ready), 32'(1));
    repeat (14) @(posedge clk);

    repeat (40) begin
      do_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'(0));
    chk("out_valid_count", 32'(n_ov), 32'(n_push));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
